// File: rtl/cop_irq.sv
// Coprocessor-0 interrupt front end: COUNT/COMPARE timer, external line
// synchroniser, and a registered request/acknowledge handshake to the pipeline.
module cop_irq #(
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_DIV   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ext_int,
  input  logic        wr_en,
  input  logic        wr_sel,
  input  logic [31:0] wr_data,
  input  logic        status_ie,
  input  logic        status_exl,
  input  logic [7:0]  im,
  input  logic [1:0]  soft_int,
  input  logic        irq_ack,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic [5:0]  hard_int,
  output logic        irq_req,
  output logic [2:0]  irq_code
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t state_reg;

  logic [SYNC_STAGES*5-1:0] sync_reg;
  logic [4:0]  sync_out;
  logic [31:0] count_reg;
  logic [31:0] compare_reg;
  logic [31:0] count_inc;
  logic        tpend_reg;
  logic        phase_reg;
  logic        cnt_wr;
  logic        cmp_wr;
  logic        tick;
  logic        match;
  logic [7:0]  ip_masked;
  logic        pend_en;
  logic [2:0]  prio_code;
  logic        irq_req_reg;
  logic [2:0]  irq_code_reg;

  // Newest sample enters at the bottom; the top slice is the synchronised value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES*5-6:0], ext_int};
    end
  end

  assign sync_out = sync_reg[SYNC_STAGES*5-1 -: 5];

  assign cnt_wr    = wr_en & ~wr_sel;
  assign cmp_wr    = wr_en &  wr_sel;
  // With COUNT_DIV = 2 only the phase-1 cycles tick; a COUNT write restarts at phase 0.
  assign tick      = ~cnt_wr & ((COUNT_DIV == 1) | phase_reg);
  assign count_inc = count_reg + 32'd1;
  assign match     = tick & (count_inc == compare_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg   <= '0;
      compare_reg <= 32'hFFFF_FFFF;
      tpend_reg   <= 1'b0;
      phase_reg   <= 1'b0;
    end else begin
      phase_reg <= cnt_wr ? 1'b0 : ~phase_reg;
      if (cnt_wr) begin
        count_reg <= wr_data;
      end else if (tick) begin
        count_reg <= count_inc;
      end
      // A COMPARE write beats a simultaneous match.
      if (cmp_wr) begin
        compare_reg <= wr_data;
        tpend_reg   <= 1'b0;
      end else if (match) begin
        tpend_reg <= 1'b1;
      end
    end
  end

  assign ip_masked = {tpend_reg, sync_out, soft_int} & im;
  assign pend_en   = (|ip_masked) & status_ie & ~status_exl;

  always_comb begin
    prio_code = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (ip_masked[i]) prio_code = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      irq_req_reg  <= 1'b0;
      irq_code_reg <= 3'd0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (pend_en) begin
            state_reg    <= S_REQ;
            irq_req_reg  <= 1'b1;
            irq_code_reg <= prio_code;
          end
        end
        S_REQ: begin
          if (irq_ack) begin
            state_reg   <= S_WAIT;
            irq_req_reg <= 1'b0;
          end else if (!pend_en) begin
            state_reg   <= S_IDLE;
            irq_req_reg <= 1'b0;
          end
        end
        S_WAIT: begin
          // pend_en already folds in EXL, so this leaves once EXL rises or the line goes away.
          if (!pend_en) state_reg <= S_IDLE;
        end
        default: begin
          state_reg   <= S_IDLE;
          irq_req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign count    = count_reg;
  assign compare  = compare_reg;
  assign hard_int = {tpend_reg, sync_out};
  assign irq_req  = irq_req_reg;
  assign irq_code = irq_code_reg;

endmodule

// File: tb/tb_cop_irq.sv
// Bench for cop_irq: two instances (2 stages / div 1 and 3 stages / div 2) share
// stimulus and are compared every cycle against a behavioural model.
module tb_cop_irq;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  ext_int;
  logic        wr_en;
  logic        wr_sel;
  logic [31:0] wr_data;
  logic        status_ie;
  logic        status_exl;
  logic [7:0]  im;
  logic [1:0]  soft_int;
  logic        irq_ack;

  logic [31:0] count0, compare0, count1, compare1;
  logic [5:0]  hard_int0, hard_int1;
  logic        irq_req0, irq_req1;
  logic [2:0]  irq_code0, irq_code1;

  cop_irq #(.SYNC_STAGES(2), .COUNT_DIV(1)) u_dut0 (
    .clk(clk), .rst(rst), .ext_int(ext_int), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_data(wr_data), .status_ie(status_ie), .status_exl(status_exl), .im(im),
    .soft_int(soft_int), .irq_ack(irq_ack), .count(count0), .compare(compare0),
    .hard_int(hard_int0), .irq_req(irq_req0), .irq_code(irq_code0)
  );

  cop_irq #(.SYNC_STAGES(3), .COUNT_DIV(2)) u_dut1 (
    .clk(clk), .rst(rst), .ext_int(ext_int), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_data(wr_data), .status_ie(status_ie), .status_exl(status_exl), .im(im),
    .soft_int(soft_int), .irq_ack(irq_ack), .count(count1), .compare(compare1),
    .hard_int(hard_int1), .irq_req(irq_req1), .irq_code(irq_code1)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model state, one slot per instance.
  int          m_stages[2] = '{2, 3};
  int          m_div[2]    = '{1, 2};
  logic [31:0] m_count[2];
  logic [31:0] m_compare[2];
  bit          m_tpend[2];
  int          m_since[2];
  bit          m_req[2];
  bit          m_block[2];
  logic [2:0]  m_code[2];
  logic [4:0]  m_hist[$];

  function automatic logic [5:0] m_hard(int d);
    return {m_tpend[d], m_hist[m_stages[d]-1]};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_count[d]   = 32'd0;
      m_compare[d] = 32'hFFFF_FFFF;
      m_tpend[d]   = 1'b0;
      m_since[d]   = 0;
      m_req[d]     = 1'b0;
      m_block[d]   = 1'b0;
      m_code[d]    = 3'd0;
    end
    m_hist = {5'd0, 5'd0, 5'd0, 5'd0};
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    logic [7:0]  mk;
    logic [31:0] nxt;
    bit          pe, tick, cwr;
    int          top;
    cwr = wr_en && !wr_sel;
    for (int d = 0; d < 2; d++) begin
      mk  = {m_hard(d), soft_int} & im;
      pe  = (mk != 8'd0) && status_ie && !status_exl;
      top = 0;
      for (int b = 0; b < 8; b++) if (mk[b]) top = b;
      if (m_req[d]) begin
        if (irq_ack) begin
          m_req[d]   = 1'b0;
          m_block[d] = 1'b1;
        end else if (!pe) begin
          m_req[d] = 1'b0;
        end
      end else if (m_block[d]) begin
        if (!pe) m_block[d] = 1'b0;
      end else if (pe) begin
        m_req[d]  = 1'b1;
        m_code[d] = 3'(top);
      end
      tick = !cwr && ((m_since[d] % m_div[d]) == m_div[d] - 1);
      nxt  = m_count[d] + 32'd1;
      if (wr_en && wr_sel) begin
        m_compare[d] = wr_data;
        m_tpend[d]   = 1'b0;
      end else if (tick && nxt == m_compare[d]) begin
        m_tpend[d] = 1'b1;
      end
      if (cwr) begin
        m_count[d] = wr_data;
        m_since[d] = 0;
      end else begin
        if (tick) m_count[d] = nxt;
        m_since[d]++;
      end
    end
    m_hist.push_front(ext_int);
    void'(m_hist.pop_back());
  endtask

  task automatic compare_all();
    check("d0.count",   count0,           m_count[0]);
    check("d0.compare", compare0,         m_compare[0]);
    check("d0.hard",    32'(hard_int0),   32'(m_hard(0)));
    check("d0.req",     32'(irq_req0),    32'(m_req[0]));
    check("d0.code",    32'(irq_code0),   32'(m_code[0]));
    check("d1.count",   count1,           m_count[1]);
    check("d1.compare", compare1,         m_compare[1]);
    check("d1.hard",    32'(hard_int1),   32'(m_hard(1)));
    check("d1.req",     32'(irq_req1),    32'(m_req[1]));
    check("d1.code",    32'(irq_code1),   32'(m_code[1]));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    compare_all();
    $display("cyc %0d wr=%b/%b cnt0=%h req0=%b code0=%0d cnt1=%h req1=%b code1=%0d",
             cyc, wr_en, wr_sel, count0, irq_req0, irq_code0, count1, irq_req1, irq_code1);
  endtask

  initial begin
    rst = 1'b0; ext_int = '0; wr_en = 1'b0; wr_sel = 1'b0; wr_data = '0;
    status_ie = 1'b0; status_exl = 1'b0; im = '0; soft_int = '0; irq_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b1;

    // Free run after reset.
    repeat (5) step();
    check("count_after5", count0, 32'd5);
    check("compare_rst",  compare0, 32'hFFFF_FFFF);
    check("req_idle",     32'(irq_req0), 32'd0);

    // Wrap and timer match, COMPARE-write clear, and write-vs-match collision.
    wr_en = 1'b1; wr_sel = 1'b0; wr_data = 32'hFFFF_FFFE;
    step();
    wr_sel = 1'b1; wr_data = 32'd1;
    step();
    check("div2_hold", count1, 32'hFFFF_FFFE);
    wr_en = 1'b0;
    step();
    check("wrap0", count0, 32'd0);
    check("div2_inc", count1, 32'hFFFF_FFFF);
    step();
    check("count_is1", count0, 32'd1);
    check("tpend_set", 32'(hard_int0[5]), 32'd1);
    wr_en = 1'b1; wr_sel = 1'b1; wr_data = 32'd5;
    step();
    check("tpend_clr", 32'(hard_int0[5]), 32'd0);
    wr_en = 1'b0;
    step();
    step();
    wr_en = 1'b1; wr_sel = 1'b1; wr_data = 32'd9;
    step();
    check("collide_cnt",  count0, 32'd5);
    check("collide_pend", 32'(hard_int0[5]), 32'd0);
    wr_en = 1'b0;

    // External line 2 through the synchroniser to a request with code 4.
    im = 8'h10; status_ie = 1'b1; status_exl = 1'b0; soft_int = 2'b00;
    ext_int = 5'b00100;
    step();
    step();
    check("sync_lat", 32'(hard_int0[2]), 32'd1);
    step();
    check("ext_req",  32'(irq_req0), 32'd1);
    check("ext_code", 32'(irq_code0), 32'd4);
    irq_ack = 1'b1;
    step();
    check("ack_drop", 32'(irq_req0), 32'd0);
    irq_ack = 1'b0;
    step();
    step();
    check("wait_hold", 32'(irq_req0), 32'd0);
    status_exl = 1'b1;
    step();
    status_exl = 1'b0;
    step();
    check("rereq", 32'(irq_req0), 32'd1);
    ext_int = 5'b0;

    // Priority: timer vs soft 0, then withdrawal by clearing IE.
    status_ie = 1'b0;
    step();
    wr_en = 1'b1; wr_sel = 1'b1; wr_data = m_count[0] + 32'd3;
    step();
    wr_en = 1'b0;
    step();
    step();
    check("tpend_again", 32'(hard_int0[5]), 32'd1);
    soft_int = 2'b01; im = 8'hFF; status_ie = 1'b1;
    step();
    check("prio_req7", 32'(irq_req0), 32'd1);
    check("prio_code7", 32'(irq_code0), 32'd7);
    status_ie = 1'b0;
    step();
    check("withdraw", 32'(irq_req0), 32'd0);
    step();
    check("no_reappear", 32'(irq_req0), 32'd0);
    im = 8'h01; status_ie = 1'b1;
    step();
    check("prio_code0", 32'(irq_code0), 32'd0);

    // Randomised traffic with one reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) ext_int = 5'($urandom);
      wr_en  = ($urandom_range(0, 9) == 0);
      wr_sel = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       wr_data = m_count[0] + 32'($urandom_range(1, 6));
        1:       wr_data = m_count[1] + 32'($urandom_range(1, 6));
        2:       wr_data = 32'hFFFF_FFFF - 32'($urandom_range(0, 4));
        default: wr_data = $urandom;
      endcase
      if ($urandom_range(0, 15) == 0) im = 8'($urandom);
      if ($urandom_range(0, 15) == 0) soft_int = 2'($urandom);
      status_ie  = ($urandom_range(0, 7) != 0);
      status_exl = ($urandom_range(0, 5) == 0);
      irq_ack    = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
